// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier operand sequencer: operand/result widths
// and the 2-bit sequencer state encoding.
package mul_pkg;

  localparam int unsigned OPW  = 32;
  localparam int unsigned RESW = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_CLEAR = 2'b10
  } state_t;

endpackage

// File: rtl/mul_operand_fifo.sv
// Synchronous operand-pair FIFO, DEPTH entries (power of 2) of WIDTH bits.
// Pushes into a full FIFO and pops from an empty one are ignored.
module mul_operand_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/mul_operand_sequencer.sv
// Queues operand pairs and runs them one at a time through the multiplier's
// start/clear handshake; products leave on a valid/ready port. Optional: MUL_TIMEOUT_EN.
module mul_operand_sequencer
  import mul_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [OPW-1:0]                  in_multiplicand,
  input  logic [OPW-1:0]                  in_multiplier,
  output logic [OPW-1:0]                  mul_multiplicand,
  output logic [OPW-1:0]                  mul_multiplier,
  output logic                            mul_op_start,
  output logic                            mul_op_clear,
  input  logic [RESW-1:0]                 mul_result,
  input  logic                            mul_op_done,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [RESW-1:0]                 out_result,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            busy
`ifdef MUL_TIMEOUT_EN
  ,
  output logic                            err_timeout
`endif
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("mul_operand_sequencer: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
  end

  state_t          r_state;
  logic [OPW-1:0]  r_mcand;
  logic [OPW-1:0]  r_mplier;
  logic            r_start;
  logic            r_clear;
  logic            r_out_valid;
  logic [RESW-1:0] r_out_result;
  logic [2*OPW-1:0] w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_out_free;
  logic            w_expired;

  assign w_pop      = (r_state == S_CLEAR);
  assign w_out_free = !r_out_valid || out_ready;

  mul_operand_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*OPW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (in_valid),
    .i_data  ({in_multiplicand, in_multiplier}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

`ifdef MUL_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);
  logic [TCW-1:0] r_tcnt;
  logic           r_err;

  assign w_expired   = (r_tcnt == TCW'(TIMEOUT_CYC - 1));
  assign err_timeout = r_err;

  // Counter idles at zero outside S_ISSUE, so every job starts a fresh window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= (r_state == S_ISSUE) && !mul_op_done && w_expired;
      if (r_state != S_ISSUE)  r_tcnt <= '0;
      else if (!w_expired)     r_tcnt <= r_tcnt + 1'b1;
    end
  end
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_start      <= 1'b0;
      r_clear      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
    end else begin
      // A capture below overrides this drain in the same cycle.
      if (out_ready) r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            {r_mcand, r_mplier} <= w_head;
            r_start             <= 1'b1;
            r_state             <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mul_op_done && w_out_free) begin
            r_out_result <= mul_result;
            r_out_valid  <= 1'b1;
            r_start      <= 1'b0;
            r_clear      <= 1'b1;
            r_state      <= S_CLEAR;
          end else if (!mul_op_done && w_expired) begin
            r_start <= 1'b0;
            r_clear <= 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_clear <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_start <= 1'b0;
          r_clear <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready         = !w_full;
  assign mul_multiplicand = r_mcand;
  assign mul_multiplier   = r_mplier;
  assign mul_op_start     = r_start;
  assign mul_op_clear     = r_clear;
  assign out_valid        = r_out_valid;
  assign out_result       = r_out_result;
  assign busy             = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Directed bench: sequencer coupled to a behavioural IDLE/EXEC/DONE multiplier.
// Timeout scenario runs only when MUL_TIMEOUT_EN is defined.
module tb_mul_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_multiplicand = '0;
  logic [31:0] in_multiplier = '0;
  logic [31:0] mul_multiplicand;
  logic [31:0] mul_multiplier;
  logic        mul_op_start;
  logic        mul_op_clear;
  logic [63:0] mul_result;
  logic        mul_op_done;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic [2:0]  fifo_count;
  logic        busy;
`ifdef MUL_TIMEOUT_EN
  logic        err_timeout;
`endif

  int n_pass = 0;
  int n_total = 0;
  int n_clear_hi = 0;
  logic [63:0] got [$];

  mul_operand_sequencer #(
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_multiplicand  (in_multiplicand),
    .in_multiplier    (in_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_op_start     (mul_op_start),
    .mul_op_clear     (mul_op_clear),
    .mul_result       (mul_result),
    .mul_op_done      (mul_op_done),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .fifo_count       (fifo_count),
    .busy             (busy)
`ifdef MUL_TIMEOUT_EN
    ,
    .err_timeout      (err_timeout)
`endif
  );

  always #2 clk = ~clk;

  // Multiplier model: start in IDLE latches operands, 3 EXEC cycles, DONE until clear.
  logic [1:0]  m_state;
  logic [1:0]  m_cnt;
  logic [63:0] m_res;
  logic        stub_hang = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_state <= 2'd0;
      m_cnt   <= 2'd0;
      m_res   <= '0;
    end else begin
      case (m_state)
        2'd0: if (mul_op_start) begin
          m_res   <= {32'd0, mul_multiplicand} * {32'd0, mul_multiplier};
          m_cnt   <= 2'd2;
          m_state <= 2'd1;
        end
        2'd1: begin
          if (mul_op_clear)      m_state <= 2'd0;
          else if (!stub_hang) begin
            if (m_cnt == 2'd0)   m_state <= 2'd2;
            else                 m_cnt   <= m_cnt - 2'd1;
          end
        end
        default: if (mul_op_clear) m_state <= 2'd0;
      endcase
    end
  end

  assign mul_op_done = (m_state == 2'd2);
  assign mul_result  = m_res;

  always begin
    @(negedge clk);
    #1;
    if (out_valid && out_ready) got.push_back(out_result);
    if (mul_op_clear) n_clear_hi++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_multiplicand = a;
    in_multiplier = b;
    @(negedge clk);
  endtask

  task automatic wait_results(input string tag, input int n);
    int cyc = 0;
    while (got.size() < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 64'(got.size()), 64'(n));
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while ((busy || out_valid) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check(tag, {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_start(input string tag);
    int cyc = 0;
    while (!mul_op_start && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, {63'd0, mul_op_start}, 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_out_result"}, out_result, 64'd0);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    check({tag, "_start"}, {63'd0, mul_op_start}, 64'd0);
    check({tag, "_clear"}, {63'd0, mul_op_clear}, 64'd0);
    check({tag, "_count"}, {61'd0, fifo_count}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_operands"}, {mul_multiplicand, mul_multiplier}, 64'd0);
  endtask

  initial begin
    int cyc;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_state("rst");
`ifdef MUL_TIMEOUT_EN
    check("rst_err", {63'd0, err_timeout}, 64'd0);
`endif

    // 1: single job
    got.delete();
    n_clear_hi = 0;
    drive(32'h7, 32'h32);
    in_valid = 1'b0;
    wait_results("t1_count", 1);
    if (got.size() >= 1) check("t1_result", got[0], 64'h15E);
    wait_idle("t1_idle");
    check("t1_clear_cycles", 64'(n_clear_hi), 64'd1);

    // 2: back-to-back pushes
    got.delete();
    check("t2_ready0", {63'd0, in_ready}, 64'd1);
    drive(32'hB, 32'h5);
    check("t2_ready1", {63'd0, in_ready}, 64'd1);
    drive(32'h26, 32'h31);
    check("t2_ready2", {63'd0, in_ready}, 64'd1);
    drive(32'h38, 32'h49);
    in_valid = 1'b0;
    wait_results("t2_count", 3);
    if (got.size() >= 3) begin
      check("t2_res0", got[0], 64'h37);
      check("t2_res1", got[1], 64'h746);
      check("t2_res2", got[2], 64'hFF8);
    end
    wait_idle("t2_idle");

    // 3: fill with output blocked, stall, then drain
    got.delete();
    out_ready = 1'b0;
    drive(32'h1, 32'h10);
    drive(32'h2, 32'h10);
    drive(32'h3, 32'h10);
    drive(32'h4, 32'h10);
    check("t3_full_ready", {63'd0, in_ready}, 64'd0);
    check("t3_full_count", {61'd0, fifo_count}, 64'd4);
    in_multiplicand = 32'h5;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t3_fifth_accept", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!mul_op_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check("t3_stall_start", {63'd0, mul_op_start}, 64'd1);
    check("t3_stall_valid", {63'd0, out_valid}, 64'd1);
    check("t3_stall_result", out_result, 64'h10);
    check("t3_stall_ready", {63'd0, in_ready}, 64'd0);
    check("t3_stall_count", {61'd0, fifo_count}, 64'd4);
    out_ready = 1'b1;
    wait_results("t3_count", 5);
    for (int i = 0; i < 5; i++)
      if (got.size() > i) check($sformatf("t3_res%0d", i), got[i], 64'((i + 1) * 16));
    wait_idle("t3_idle");
    check("t3_total", 64'(got.size()), 64'd5);

    // 4: push and pop in the same cycle at count 3
    got.delete();
    drive(32'h6, 32'h7);
    drive(32'h8, 32'h8);
    drive(32'hA, 32'hA);
    in_valid = 1'b0;
    cyc = 0;
    while (!mul_op_clear && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_in_clear", {63'd0, mul_op_clear}, 64'd1);
    check("t4_count_before", {61'd0, fifo_count}, 64'd3);
    drive(32'h9, 32'h9);
    in_valid = 1'b0;
    check("t4_count_after", {61'd0, fifo_count}, 64'd3);
    wait_results("t4_count", 4);
    if (got.size() >= 4) begin
      check("t4_res0", got[0], 64'h2A);
      check("t4_res1", got[1], 64'h40);
      check("t4_res2", got[2], 64'h64);
      check("t4_res3", got[3], 64'h51);
    end
    wait_idle("t4_idle");

    // 5: reset during S_ISSUE
    drive(32'h1234, 32'h10);
    in_valid = 1'b0;
    wait_start("t5_start");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("t5_rst");
    got.delete();
    drive(32'h2, 32'h3);
    in_valid = 1'b0;
    wait_results("t5_count", 1);
    if (got.size() >= 1) check("t5_result", got[0], 64'h6);
    wait_idle("t5_idle");
    check("t5_total", 64'(got.size()), 64'd1);

`ifdef MUL_TIMEOUT_EN
    // 6: multiplier never finishes
    got.delete();
    stub_hang = 1'b1;
    drive(32'h5, 32'h5);
    in_valid = 1'b0;
    wait_start("t6_start");
    cyc = 0;
    while (!err_timeout && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_err_cycle", 64'(cyc), 64'd8);
    @(negedge clk);
    check("t6_err_pulse", {63'd0, err_timeout}, 64'd0);
    stub_hang = 1'b0;
    wait_idle("t6_idle");
    check("t6_no_output", 64'(got.size()), 64'd0);
    drive(32'h3, 32'h4);
    in_valid = 1'b0;
    wait_results("t6_next_count", 1);
    if (got.size() >= 1) check("t6_next_result", got[0], 64'hC);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
